// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack controller and its storage.
package stack_pkg;

    // Per-edge operation, indexed as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module stack_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one word per edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is combinational so the top-of-stack peek has no latency.
    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_ctrl.sv
// LIFO stack controller: occupancy count, op decode, registered pop data,
// combinational top-of-stack peek and sticky overflow/underflow flags.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned AF_THRESH = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clr_err,
    input  logic signed [WIDTH-1:0]   data_in,
    output logic signed [WIDTH-1:0]   data_out,
    output logic                      pop_valid,
    output logic signed [WIDTH-1:0]   top,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             pv_q, pv_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    op_e op;

    assign op = op_e'({push, pop});

    // Status flags decode straight from the count register, so they are
    // as clean as the register itself.
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AF_THRESH));

    // Top entry sits at count-1; the wrapped value when empty is never used.
    assign mem_raddr = AW'(count_q - CW'(1));

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Next-state decode for count, pop data, strobe, flags and the write port.
    always_comb begin
        count_d   = count_q;
        dout_d    = dout_q;
        pv_d      = 1'b0;
        // Clear first so a same-edge set event below takes priority.
        ovf_d     = clr_err ? 1'b0 : ovf_q;
        unf_d     = clr_err ? 1'b0 : unf_q;
        mem_we    = 1'b0;
        mem_waddr = AW'(count_q);
        mem_wdata = data_in;

        unique case (op)
            OP_IDLE: begin
            end
            OP_PUSH: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    dout_d  = mem_rdata;
                    pv_d    = 1'b1;
                    count_d = count_q - CW'(1);
                end
            end
            OP_REPLACE: begin
                if (empty) begin
                    // Push proceeds into slot 0; the pop half is an underflow.
                    mem_we  = 1'b1;
                    count_d = CW'(1);
                    unf_d   = 1'b1;
                end else begin
                    // Old top leaves through data_out while the new word
                    // overwrites it in place; occupancy is unchanged.
                    dout_d    = mem_rdata;
                    pv_d      = 1'b1;
                    mem_we    = 1'b1;
                    mem_waddr = mem_raddr;
                end
            end
        endcase
    end

    // Controller state with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dout_q  <= '0;
            pv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            pv_q    <= pv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count     = count_q;
    assign data_out  = dout_q;
    assign pop_valid = pv_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign top       = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_stack_ctrl;

    localparam int unsigned W   = 8;
    localparam int unsigned D   = 4;
    localparam int unsigned AFT = 3;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       pop_valid;
    logic [7:0] top;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [7:0] m_stack[$];
    logic [7:0] m_dout;
    logic       m_pv;
    logic       m_ovf;
    logic       m_unf;

    stack_ctrl #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AF_THRESH (AFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .clr_err     (clr_err),
        .data_in     (data_in),
        .data_out    (data_out),
        .pop_valid   (pop_valid),
        .top         (top),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_top();
        return (m_stack.size() > 0) ? m_stack[m_stack.size() - 1] : 8'h00;
    endfunction

    task automatic model_reset();
        m_stack.delete();
        m_dout = 8'h00;
        m_pv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Apply one edge's worth of behaviour to the model.
    task automatic model_step(input logic p, input logic q, input logic c, input logic [7:0] d);
        int n;
        n    = m_stack.size();
        m_pv = 1'b0;
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (p && q) begin
            if (n == 0) begin
                m_stack.push_back(d);
                m_unf = 1'b1;
            end else begin
                m_dout         = m_stack[n - 1];
                m_pv           = 1'b1;
                m_stack[n - 1] = d;
            end
        end else if (p) begin
            if (n == int'(D)) m_ovf = 1'b1;
            else              m_stack.push_back(d);
        end else if (q) begin
            if (n == 0) begin
                m_unf = 1'b1;
            end else begin
                m_dout = m_stack.pop_back();
                m_pv   = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = m_stack.size();
        check({tag, " count"},       32'(count),       32'(n));
        check({tag, " top"},         32'(top),         32'(m_top()));
        check({tag, " empty"},       32'(empty),       32'(n == 0));
        check({tag, " full"},        32'(full),        32'(n == int'(D)));
        check({tag, " almost_full"}, 32'(almost_full), 32'(n >= int'(AFT)));
        check({tag, " data_out"},    32'(data_out),    32'(m_dout));
        check({tag, " pop_valid"},   32'(pop_valid),   32'(m_pv));
        check({tag, " overflow"},    32'(overflow),    32'(m_ovf));
        check({tag, " underflow"},   32'(underflow),   32'(m_unf));
    endtask

    // Drive one cycle, sample 1 time unit after the edge, compare to model.
    task automatic step(input string tag, input logic p, input logic q, input logic c,
                        input logic [7:0] d);
        push    = p;
        pop     = q;
        clr_err = c;
        data_in = d;
        @(posedge clk);
        #1;
        model_step(p, q, c, d);
        compare_all(tag);
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        data_in = 8'h00;
        model_reset();
        #12;
        compare_all("reset");
        rst = 1'b0;

        // 1: fill to almost full, then full.
        step("s1 push", 1, 0, 0, 8'h11);
        step("s1 push", 1, 0, 0, 8'h22);
        step("s1 push", 1, 0, 0, 8'h33);
        check("s1 af", 32'(almost_full), 32'd1);
        check("s1 top", 32'(top), 32'h33);
        step("s1 push4", 1, 0, 0, 8'h44);
        check("s1 full", 32'(full), 32'd1);

        // 2: overflow drop and clear.
        step("s2 ovf", 1, 0, 0, 8'h55);
        check("s2 ovf flag", 32'(overflow), 32'd1);
        check("s2 top", 32'(top), 32'h44);
        step("s2 clr", 0, 0, 1, 8'h00);
        check("s2 ovf clr", 32'(overflow), 32'd0);

        // 3: drain in LIFO order, then underflow.
        step("s3 pop", 0, 1, 0, 8'h00);
        check("s3 d44", 32'(data_out), 32'h44);
        step("s3 pop", 0, 1, 0, 8'h00);
        step("s3 pop", 0, 1, 0, 8'h00);
        step("s3 pop", 0, 1, 0, 8'h00);
        check("s3 d11", 32'(data_out), 32'h11);
        step("s3 idle", 0, 0, 0, 8'h00);
        step("s3 unf", 0, 1, 0, 8'h00);
        check("s3 unf flag", 32'(underflow), 32'd1);
        check("s3 hold", 32'(data_out), 32'h11);
        step("s3 clr", 0, 0, 1, 8'h00);

        // 4: replace-top, including while full.
        step("s4 push", 1, 0, 0, 8'h11);
        step("s4 push", 1, 0, 0, 8'h22);
        step("s4 repl", 1, 1, 0, 8'h7F);
        check("s4 d22", 32'(data_out), 32'h22);
        check("s4 top", 32'(top), 32'h7F);
        step("s4 push", 1, 0, 0, 8'h33);
        step("s4 push", 1, 0, 0, 8'h44);
        step("s4 replfull", 1, 1, 0, 8'h80);
        check("s4 no ovf", 32'(overflow), 32'd0);
        check("s4 top80", 32'(top), 32'h80);

        // 5: push+pop on empty, with a simultaneous clear.
        async_reset("s5 rst");
        step("s5 repl empty", 1, 1, 1, 8'h05);
        check("s5 unf wins", 32'(underflow), 32'd1);
        check("s5 count", 32'(count), 32'd1);

        // 6: asynchronous reset mid-cycle right after a pop.
        async_reset("s6 rst0");
        step("s6 push", 1, 0, 0, 8'h11);
        step("s6 push", 1, 0, 0, 8'h22);
        step("s6 pop", 0, 1, 0, 8'h00);
        async_reset("s6 rst");
        check("s6 dout0", 32'(data_out), 32'd0);
        step("s6 unf", 0, 1, 0, 8'h00);
        check("s6 unf flag", 32'(underflow), 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd rst");
            end else begin
                step("rnd",
                     logic'($urandom_range(0, 99) < 55),
                     logic'($urandom_range(0, 99) < 45),
                     logic'($urandom_range(0, 99) < 5),
                     8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Parametrised LIFO stack, successor to the team's basic push/pop stack.
- Adds registered pop data with a valid strobe, a combinational top-of-stack peek, an occupancy count and an almost-full threshold.
- Adds a push+pop "replace-top" operation and sticky overflow/underflow error flags.
- Sits between an expression/command producer and its consumer as operand or return storage.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 256, number of entries (≥2; need not be a power of 2).
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- push  in  1  push request.
- pop  in  1  pop request.
- clr_err  in  1  synchronous clear of overflow/underflow.
- data_in  in  WIDTH  push data, signed.
- data_out  out  WIDTH  popped word, registered, signed.
- pop_valid  out  1  one-cycle strobe: data_out was updated by this edge.
- top  out  WIDTH  current top entry, combinational peek; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was made on an empty stack.

Behaviour:
- Reset (async, any time, including mid-operation):
  - count=0, data_out=0, pop_valid=0, overflow=0, underflow=0.
  - Hence empty=1, full=0, almost_full=0, top=0.
  - Memory contents are not cleared.
- full, empty and almost_full are decoded purely from the count register: no extra latency, glitch-free relative to clk.
- Per-edge operation, selected from {push,pop}:
  - IDLE (0,0): no state change; pop_valid=0.
  - PUSH (1,0), !full: mem[count]<=data_in; count+1.
  - PUSH (1,0), full: word dropped; count unchanged; overflow<=1.
  - POP (0,1), !empty: data_out<=mem[count-1]; pop_valid<=1; count-1.
  - POP (0,1), empty: underflow<=1; pop_valid=0; data_out holds.
  - REPLACE (1,1), !empty:
    - data_out<=old top; pop_valid<=1.
    - mem[count-1]<=data_in; count unchanged.
    - Legal when full; does not set overflow.
  - (1,1), empty: push is performed (count 0→1, mem[0]<=data_in); pop is ignored; underflow<=1; pop_valid=0.
- pop_valid is high for exactly one cycle per accepted pop or replace.
- data_out holds its last value while pop_valid=0. It is never driven to Z or X.
- top = mem[count-1] when count>0, else 0. It reflects a push or replace on the cycle after the edge.
- Sticky flags:
  - Once set, they remain set until clr_err or reset.
  - If a set event and clr_err occur on the same edge, set wins.
- Latency:
  - Pop data is valid one edge after the request.
  - A pushed word is visible on top after one edge.
  - Back-to-back push/pop at full rate is allowed, with no bubbles.
- count never exceeds DEPTH and never wraps below 0.

Decomposition:
- Package stack_pkg:
  - Op encoding OP_IDLE=2'b00, OP_PUSH=2'b10, OP_POP=2'b01, OP_REPLACE=2'b11, indexed as {push,pop}.
  - Function cnt_w(depth) returning $clog2(depth+1).
- Sub-module stack_mem (WIDTH, DEPTH):
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - Controller drives raddr=count-1 (don't-care when empty). The same read port feeds both top and data_out.
- Top level stack_ctrl holds count, the op decode, output registers and error flags.

Test Plan:
All scenarios use WIDTH=8, DEPTH=4, AF_THRESH=3.
1. Reset then push 0x11, 0x22, 0x33 → count=3, almost_full=1, top=0x33, empty=0; push 0x44 → full=1, count=4.
2. From full, push 0x55 → dropped, overflow=1, top=0x44, count=4; pulse clr_err → overflow=0.
3. Pop ×4 from {11,22,33,44} → data_out 0x44, 0x33, 0x22, 0x11 each with a one-cycle pop_valid, one edge after each pop; empty=1, top=0; a 5th pop → underflow=1, pop_valid=0, data_out holds 0x11.
4. With {11,22}, push=pop=1 with data_in=0x7F → data_out=0x22, pop_valid=1, count=2, top=0x7F; repeat while full with data_in=0x80 → no overflow, top=0x80 (signed -128).
5. From empty, push=pop=1 with data_in=0x05 → count=1, top=0x05, underflow=1, pop_valid=0; same edge with clr_err=1 → underflow remains 1.
6. Push 0x11, 0x22, assert rst asynchronously between edges → count=0, empty=1, pop_valid=0, data_out=0 immediately; after release, pop → underflow=1.
